// File: rtl/code_converter_seq.sv
// Sequential code converter: binary->Gray, Gray->binary and iterative binary->BCD (double-dabble).
// Optional CODE_CONV_PARITY_EN adds a registered out_parity output.
module code_converter_seq #(
    parameter int N          = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [N-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_data,
    output logic [4*BCD_DIGITS-1:0] out_bcd,
    output logic                    out_err
`ifdef CODE_CONV_PARITY_EN
    ,
    output logic                    out_parity
`endif
);
    localparam int BW = 4 * BCD_DIGITS;
    localparam int SW = BW + N;
    localparam int CW = $clog2(N + 1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    if (pow10(BCD_DIGITS) <= (longint'(1) << N) - 1) begin : g_bcd_width_chk
        $error("BCD_DIGITS too small to hold 2^N-1");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          err_q, err_d;
    logic          par_q, par_d;
    logic [SW-1:0] sh_adj, sh_shift;
    logic [N-1:0]  g2b;

    // Double-dabble step: correct digits >= 5 before the shift so they carry into the next digit.
    always_comb begin
        sh_adj = sh_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (sh_q[N+4*d +: 4] >= 4'd5) sh_adj[N+4*d +: 4] = sh_q[N+4*d +: 4] + 4'd3;
        end
        sh_shift = sh_adj << 1;
    end

    always_comb begin
        g2b[N-1] = in_data[N-1];
        for (int i = N - 2; i >= 0; i--) g2b[i] = g2b[i+1] ^ in_data[i];
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    bcd_d = '0;
                    case (in_mode)
                        2'b00: begin
                            data_d  = in_data ^ (in_data >> 1);
                            par_d   = ^(in_data ^ (in_data >> 1));
                            state_d = DONE;
                        end
                        2'b01: begin
                            data_d  = g2b;
                            par_d   = ^g2b;
                            state_d = DONE;
                        end
                        2'b10: begin
                            sh_d    = {{BW{1'b0}}, in_data};
                            data_d  = '0;
                            par_d   = 1'b0;
                            state_d = CONV;
                        end
                        default: begin
                            data_d  = '0;
                            err_d   = 1'b1;
                            par_d   = 1'b0;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            CONV: begin
                sh_d  = sh_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    bcd_d   = sh_shift[SW-1 -: BW];
                    par_d   = ^sh_shift[SW-1 -: BW];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            par_q   <= par_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_bcd   = bcd_q;
    assign out_err   = err_q;
`ifdef CODE_CONV_PARITY_EN
    assign out_parity = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule
